// File: rtl/hms_time_counter_pkg.sv
// Shared constants and load-validation helper for the hours/minutes/seconds BCD time base.
package hms_time_counter_pkg;

    localparam int UNITS_MAX     = 9;
    localparam int TENS_MAX      = 5;
    localparam int HOUR_MAX_24   = 23;
    localparam int HOUR_MIN_12   = 1;
    localparam int HOUR_MAX_12   = 12;
    localparam int RESET_HOUR_24 = 0;
    localparam int RESET_HOUR_12 = 12;

    // h = {tens[1:0], units[3:0]}, m/s = {tens[2:0], units[3:0]}
    function automatic logic bcd_time_valid(input logic [5:0] h, input logic [6:0] m,
                                            input logic [6:0] s, input logic twelve_hour);
        int  hv;
        logic ok;
        hv = int'(h[5:4]) * 10 + int'(h[3:0]);
        ok = (int'(h[3:0]) <= UNITS_MAX) && (int'(m[3:0]) <= UNITS_MAX) &&
             (int'(s[3:0]) <= UNITS_MAX) && (int'(m[6:4]) <= TENS_MAX) &&
             (int'(s[6:4]) <= TENS_MAX);
        if (twelve_hour) begin
            ok = ok && (hv >= HOUR_MIN_12) && (hv <= HOUR_MAX_12);
        end else begin
            ok = ok && (hv <= HOUR_MAX_24);
        end
        return ok;
    endfunction

endpackage

// File: rtl/hms_time_counter_bcd_digit.sv
// Single mod-(MAX+1) BCD digit with load > inc > dec priority and a combinational wrap flag.
module bcd_digit #(
    parameter int W         = 4,
    parameter int MAX       = 9,
    parameter int RESET_VAL = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] ld_val_i,
    output logic [W-1:0] q_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MAX_V   = W'(MAX);
    localparam logic [W-1:0] RESET_V = W'(RESET_VAL);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = ld_val_i;
        end else if (inc_i) begin
            q_d = (q_q == MAX_V) ? '0 : q_q + 1'b1;
        end else if (dec_i) begin
            q_d = (q_q == '0) ? MAX_V : q_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RESET_V;
        end else begin
            q_q <= q_d;
        end
    end

    assign wrap_o = !load_i && ((inc_i && (q_q == MAX_V)) || (dec_i && !inc_i && (q_q == '0)));
    assign q_o    = q_q;

endmodule

// File: rtl/hms_time_counter.sv
// BCD time-of-day counter: tick ripple, prioritised manual adjust, validated load, midnight pulse.
module hms_time_counter
    import hms_time_counter_pkg::*;
#(
    parameter bit TWELVE_HOUR    = 1'b0,
    parameter bit ADJ_CLEARS_SEC = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       run_i,
    input  logic       inc_min_i,
    input  logic       dec_min_i,
    input  logic       inc_hour_i,
    input  logic       dec_hour_i,
    input  logic       load_i,
    input  logic [1:0] ld_h_tens_i,
    input  logic [3:0] ld_h_units_i,
    input  logic [2:0] ld_m_tens_i,
    input  logic [3:0] ld_m_units_i,
    input  logic [2:0] ld_s_tens_i,
    input  logic [3:0] ld_s_units_i,
    input  logic       ld_pm_i,
    output logic [3:0] s_units_o,
    output logic [2:0] s_tens_o,
    output logic [3:0] m_units_o,
    output logic [2:0] m_tens_o,
    output logic [3:0] h_units_o,
    output logic [1:0] h_tens_o,
    output logic       pm_o,
    output logic       day_pulse_o,
    output logic       load_err_o
);

    localparam int RESET_HOUR = TWELVE_HOUR ? RESET_HOUR_12 : RESET_HOUR_24;

    logic [3:0] su_q, mu_q, hu_q, hu_ld;
    logic [2:0] st_q, mt_q;
    logic [1:0] ht_q, ht_ld;
    logic       su_wrap, st_wrap, mu_wrap, mt_wrap, hu_wrap, ht_wrap;
    logic       pm_q, pm_d, day_q, day_d, err_q;
    logic       load_ok, any_adj, adj_ih, adj_dh, adj_im, adj_dm, tick_en, adj_en;
    logic       sec_carry, min_carry, mu_inc, sec_ld, hour_ld;
    logic [3:0] su_ldv;
    logic [2:0] st_ldv;
    int         h_cur, h_new;

    assign load_ok = load_i && bcd_time_valid({ld_h_tens_i, ld_h_units_i},
                                              {ld_m_tens_i, ld_m_units_i},
                                              {ld_s_tens_i, ld_s_units_i}, TWELVE_HOUR);
    // Exactly one event class is honoured per cycle; a rejected load still swallows the cycle.
    assign any_adj = inc_hour_i || dec_hour_i || inc_min_i || dec_min_i;
    assign adj_en  = !load_i && any_adj;
    assign adj_ih  = adj_en && inc_hour_i;
    assign adj_dh  = adj_en && !inc_hour_i && dec_hour_i;
    assign adj_im  = adj_en && !inc_hour_i && !dec_hour_i && inc_min_i;
    assign adj_dm  = adj_en && !inc_hour_i && !dec_hour_i && !inc_min_i && dec_min_i;
    assign tick_en = !load_i && !any_adj && run_i && tick_i;

    assign sec_ld    = load_ok || (adj_en && ADJ_CLEARS_SEC);
    assign su_ldv    = load_ok ? ld_s_units_i : 4'd0;
    assign st_ldv    = load_ok ? ld_s_tens_i : 3'd0;
    assign sec_carry = tick_en && su_wrap && st_wrap;
    assign mu_inc    = sec_carry || adj_im;
    assign min_carry = sec_carry && mu_wrap && mt_wrap;

    bcd_digit #(.W(4), .MAX(UNITS_MAX), .RESET_VAL(0)) u_s_units (
        .clk_i, .rst_ni, .inc_i(tick_en), .dec_i(1'b0), .load_i(sec_ld),
        .ld_val_i(su_ldv), .q_o(su_q), .wrap_o(su_wrap));
    bcd_digit #(.W(3), .MAX(TENS_MAX), .RESET_VAL(0)) u_s_tens (
        .clk_i, .rst_ni, .inc_i(tick_en && su_wrap), .dec_i(1'b0), .load_i(sec_ld),
        .ld_val_i(st_ldv), .q_o(st_q), .wrap_o(st_wrap));
    bcd_digit #(.W(4), .MAX(UNITS_MAX), .RESET_VAL(0)) u_m_units (
        .clk_i, .rst_ni, .inc_i(mu_inc), .dec_i(adj_dm), .load_i(load_ok),
        .ld_val_i(ld_m_units_i), .q_o(mu_q), .wrap_o(mu_wrap));
    bcd_digit #(.W(3), .MAX(TENS_MAX), .RESET_VAL(0)) u_m_tens (
        .clk_i, .rst_ni, .inc_i(mu_inc && mu_wrap), .dec_i(adj_dm && mu_wrap), .load_i(load_ok),
        .ld_val_i(ld_m_tens_i), .q_o(mt_q), .wrap_o(mt_wrap));

    // Hours wrap at 23/12 rather than at digit boundaries, so both hour digits are loaded here.
    always_comb begin
        h_cur   = int'(ht_q) * 10 + int'(hu_q);
        h_new   = h_cur;
        pm_d    = pm_q;
        day_d   = 1'b0;
        hour_ld = 1'b0;
        if (load_ok) begin
            h_new   = int'(ld_h_tens_i) * 10 + int'(ld_h_units_i);
            pm_d    = TWELVE_HOUR ? ld_pm_i : 1'b0;
            hour_ld = 1'b1;
        end else if (adj_ih || min_carry) begin
            hour_ld = 1'b1;
            if (TWELVE_HOUR) begin
                h_new = (h_cur == HOUR_MAX_12) ? HOUR_MIN_12 : h_cur + 1;
                if (h_cur == HOUR_MAX_12 - 1) begin
                    pm_d  = !pm_q;
                    day_d = min_carry && pm_q;
                end
            end else begin
                h_new = (h_cur == HOUR_MAX_24) ? 0 : h_cur + 1;
                day_d = min_carry && (h_cur == HOUR_MAX_24);
            end
        end else if (adj_dh) begin
            hour_ld = 1'b1;
            if (TWELVE_HOUR) begin
                h_new = (h_cur == HOUR_MIN_12) ? HOUR_MAX_12 : h_cur - 1;
                if (h_cur == HOUR_MAX_12) begin
                    pm_d = !pm_q;
                end
            end else begin
                h_new = (h_cur == 0) ? HOUR_MAX_24 : h_cur - 1;
            end
        end
        ht_ld = 2'(h_new / 10);
        hu_ld = 4'(h_new % 10);
    end

    bcd_digit #(.W(4), .MAX(UNITS_MAX), .RESET_VAL(RESET_HOUR % 10)) u_h_units (
        .clk_i, .rst_ni, .inc_i(1'b0), .dec_i(1'b0), .load_i(hour_ld),
        .ld_val_i(hu_ld), .q_o(hu_q), .wrap_o(hu_wrap));
    bcd_digit #(.W(2), .MAX(2), .RESET_VAL(RESET_HOUR / 10)) u_h_tens (
        .clk_i, .rst_ni, .inc_i(1'b0), .dec_i(1'b0), .load_i(hour_ld),
        .ld_val_i(ht_ld), .q_o(ht_q), .wrap_o(ht_wrap));

    logic unused_hour_wrap;
    assign unused_hour_wrap = hu_wrap ^ ht_wrap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pm_q  <= 1'b0;
            day_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pm_q  <= pm_d;
            day_q <= day_d;
            err_q <= load_i && !load_ok;
        end
    end

    assign s_units_o   = su_q;
    assign s_tens_o    = st_q;
    assign m_units_o   = mu_q;
    assign m_tens_o    = mt_q;
    assign h_units_o   = hu_q;
    assign h_tens_o    = ht_q;
    assign pm_o        = pm_q;
    assign day_pulse_o = day_q;
    assign load_err_o  = err_q;

endmodule
